// File: rtl/sdram_client_arbiter.sv
// Round-robin arbiter sharing one SDRAMBus port among N_CLIENTS cores.
// A granted command is held until SDRAMBus completes; completion is routed back to that client only.
module sdram_arb_lane #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic                     rd,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     req,
  output logic [ADDR_W+DATA_W:0]   cmd
);
  // Write wins when both read and write are raised.
  assign req = rd | wr;
  assign cmd = {wr, addr, wdata};
endmodule

module sdram_client_arbiter #(
  parameter int N_CLIENTS = 5,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_CLIENTS-1:0]          cli_read,
  input  logic [N_CLIENTS-1:0]          cli_write,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cli_addr,
  input  logic [N_CLIENTS*DATA_W-1:0]   cli_writedata,
  output logic [DATA_W-1:0]             cli_readdata,
  output logic [N_CLIENTS-1:0]          cli_finished,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished,
  output logic                          o_busy,
  output logic [$clog2(N_CLIENTS)-1:0]  o_grant
);
  localparam int GW = $clog2(N_CLIENTS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic [N_CLIENTS-1:0] req;
  cmd_t [N_CLIENTS-1:0] cmd_v;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_lane
    sdram_arb_lane #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_lane (
      .rd    (cli_read[i]),
      .wr    (cli_write[i]),
      .addr  (cli_addr[i*ADDR_W +: ADDR_W]),
      .wdata (cli_writedata[i*DATA_W +: DATA_W]),
      .req   (req[i]),
      .cmd   (cmd_v[i])
    );
  end

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] grant;
  logic [GW-1:0] pick;
  logic          found;
  int            sel_idx;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    found   = 1'b0;
    pick    = rr_ptr;
    sel_idx = 0;
    for (int k = 1; k <= N_CLIENTS; k++) begin
      sel_idx = (int'(rr_ptr) + k) % N_CLIENTS;
      if (!found && req[sel_idx]) begin
        found = 1'b1;
        pick  = GW'(sel_idx);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= GW'(N_CLIENTS - 1);
      grant           <= '0;
      sdram_read      <= 1'b0;
      sdram_write     <= 1'b0;
      sdram_addr      <= '0;
      sdram_writedata <= '0;
      cli_finished    <= '0;
      cli_readdata    <= '0;
    end else begin
      cli_finished <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant           <= pick;
            rr_ptr          <= pick;
            sdram_write     <= cmd_v[pick].wr;
            sdram_read      <= ~cmd_v[pick].wr;
            sdram_addr      <= cmd_v[pick].addr;
            sdram_writedata <= cmd_v[pick].wdata;
            state           <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (sdram_finished) begin
            sdram_read      <= 1'b0;
            sdram_write     <= 1'b0;
            sdram_addr      <= '0;
            sdram_writedata <= '0;
            cli_finished    <= {{(N_CLIENTS-1){1'b0}}, 1'b1} << grant;
            cli_readdata    <= sdram_readdata;
            state           <= ST_RELEASE;
          end
        end
        // Gives the finished client a cycle to drop its request before re-arbitration.
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy  = (state == ST_BUSY) || (state == ST_RELEASE);
  assign o_grant = grant;

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed plus randomized bench for sdram_client_arbiter with a round-robin reference model.
module tb_sdram_client_arbiter;
  localparam int N  = 5;
  localparam int AW = 23;
  localparam int DW = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [N-1:0]      cli_read, cli_write;
  logic [N*AW-1:0]   cli_addr;
  logic [N*DW-1:0]   cli_writedata;
  logic [DW-1:0]     cli_readdata;
  logic [N-1:0]      cli_finished;
  logic              sdram_read, sdram_write;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_writedata, sdram_readdata;
  logic              sdram_finished, o_busy;
  logic [2:0]        o_grant;

  int passed = 0;
  int total  = 0;
  int model_rr;

  always #5 i_clk = ~i_clk;

  sdram_client_arbiter #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .cli_read(cli_read), .cli_write(cli_write),
    .cli_addr(cli_addr), .cli_writedata(cli_writedata),
    .cli_readdata(cli_readdata), .cli_finished(cli_finished),
    .sdram_read(sdram_read), .sdram_write(sdram_write),
    .sdram_addr(sdram_addr), .sdram_writedata(sdram_writedata),
    .sdram_readdata(sdram_readdata), .sdram_finished(sdram_finished),
    .o_busy(o_busy), .o_grant(o_grant)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Next winner: first requesting index after the last winner, wrapping around.
  function automatic int rr_pick(logic [N-1:0] m, int rr);
    for (int k = 1; k <= N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic set_req(int c, bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    cli_read[c]               = rd;
    cli_write[c]              = wr;
    cli_addr[c*AW +: AW]      = a;
    cli_writedata[c*DW +: DW] = d;
  endtask

  // Called in an IDLE cycle with requests set; returns in the IDLE cycle after RELEASE.
  task automatic serve(string tag, int lat, logic [DW-1:0] rdata, int late, bit rereq, output int w);
    logic [N-1:0] m;
    bit           exp_wr, sv_rd, sv_wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int           waited;
    m = cli_read | cli_write;
    w = rr_pick(m, model_rr);
    if (w < 0) begin
      check({tag, "/no_request"}, 1, 0);
      return;
    end
    sv_rd  = cli_read[w];
    sv_wr  = cli_write[w];
    exp_wr = cli_write[w];
    ea     = cli_addr[w*AW +: AW];
    ed     = cli_writedata[w*DW +: DW];
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!(sdram_read | sdram_write) && waited < 8);
    check({tag, "/cmd_latency"}, waited, 1);
    if (!(sdram_read | sdram_write)) return;
    check({tag, "/grant"}, o_grant, w);
    check({tag, "/write"}, sdram_write, exp_wr);
    check({tag, "/read"}, sdram_read, !exp_wr);
    check({tag, "/addr"}, sdram_addr, ea);
    if (exp_wr) check({tag, "/wdata"}, sdram_writedata, ed);
    check({tag, "/busy"}, o_busy, 1);
    if (late >= 0) set_req(late, 1, 0, AW'($urandom), DW'($urandom));
    for (int i = 0; i < lat; i++) begin
      tick();
      check({tag, "/held"}, {sdram_read, sdram_write, o_grant}, {!exp_wr, exp_wr, 3'(w)});
      check({tag, "/no_early_fin"}, cli_finished, 0);
    end
    sdram_finished = 1'b1;
    sdram_readdata = rdata;
    tick();
    sdram_finished = 1'b0;
    sdram_readdata = DW'($urandom);
    check({tag, "/finished"}, cli_finished, 5'b1 << w);
    check({tag, "/rdata"}, cli_readdata, rdata);
    check({tag, "/cmd_drop"}, {sdram_read, sdram_write, sdram_addr, sdram_writedata}, 0);
    check({tag, "/busy_release"}, o_busy, 1);
    set_req(w, 0, 0, ea, ed);
    tick();
    check({tag, "/fin_one_cycle"}, cli_finished, 0);
    check({tag, "/idle"}, {o_busy, sdram_read, sdram_write}, 0);
    check({tag, "/rdata_hold"}, cli_readdata, rdata);
    model_rr = w;
    if (rereq) set_req(w, sv_rd, sv_wr, ea, ed);
  endtask

  initial begin
    int g;
    int order [6] = '{0, 1, 2, 3, 4, 0};
    i_rst = 1'b1;
    cli_read = '0; cli_write = '0; cli_addr = '0; cli_writedata = '0;
    sdram_readdata = '0; sdram_finished = 1'b0;
    tick(); tick();
    check("reset_outputs", {cli_finished, cli_readdata, sdram_read, sdram_write, sdram_addr,
                            sdram_writedata, o_busy, o_grant}, 0);
    i_rst = 1'b0;
    model_rr = N - 1;

    // Single read from client 4 with three held cycles.
    set_req(4, 1, 0, 23'h000100, 32'h0);
    serve("t1", 3, 32'hDEADBEEF, -1, 0, g);
    check("t1/who", g, 4);

    // Write to the top address from client 3.
    set_req(3, 0, 1, 23'h7FFFFF, 32'h12345678);
    serve("t2", 2, 32'h0BAD0BAD, -1, 0, g);
    check("t2/who", g, 3);

    // Read+write together is issued as a write; client 0 arrives mid-transaction.
    set_req(2, 1, 1, 23'h0ABCDE, 32'hCAFEF00D);
    serve("t6a", 1, 32'h11111111, 0, 0, g);
    check("t6a/who", g, 2);
    serve("t6b", 0, 32'h22222222, -1, 0, g);
    check("t6b/who", g, 0);

    // Move the pointer to 2, then clients 1 and 3 contend.
    set_req(2, 1, 0, 23'h000222, 32'h0);
    serve("t4a", 2, 32'h33333333, -1, 0, g);
    set_req(1, 1, 0, 23'h000111, 32'h0);
    set_req(3, 0, 1, 23'h000333, 32'h33330000);
    serve("t4b", 1, 32'h44444444, -1, 0, g);
    check("t4b/who", g, 3);
    serve("t4c", 1, 32'h55555555, -1, 0, g);
    check("t4c/who", g, 1);

    // Reset while BUSY drops the command with no completion; stray finish is ignored.
    set_req(1, 1, 0, 23'h001234, 32'h0);
    tick();
    check("t5/cmd", sdram_read, 1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    cli_read = '0; cli_write = '0;
    check("t5/after_reset", {cli_finished, sdram_read, sdram_write, sdram_addr, o_busy, o_grant}, 0);
    sdram_finished = 1'b1;
    sdram_readdata = 32'hFFFFFFFF;
    tick();
    sdram_finished = 1'b0;
    check("t5/stray_fin", {cli_finished, cli_readdata, sdram_read, o_busy}, 0);
    tick();
    check("t5/quiet", {cli_finished, o_busy}, 0);
    model_rr = N - 1;

    // All five request continuously.
    for (int c = 0; c < N; c++) set_req(c, 1, 0, AW'(c * 16 + 5), 32'h0);
    for (int i = 0; i < 6; i++) begin
      serve("t3", $urandom_range(0, 2), DW'($urandom), -1, 1, g);
      check("t3/order", g, order[i]);
    end
    cli_read = '0; cli_write = '0;
    tick();
    check("t3/drained", o_busy, 0);

    // Randomized traffic against the reference model.
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < N; c++)
        if (!cli_read[c] && !cli_write[c] && $urandom_range(0, 1) == 1) begin
          int op;
          op = $urandom_range(1, 3);
          set_req(c, op[0], op[1], AW'($urandom), DW'($urandom));
        end
      if ((cli_read | cli_write) == '0) begin
        int c;
        c = $urandom_range(0, N - 1);
        set_req(c, 1, 0, AW'($urandom), DW'($urandom));
      end
      serve("rnd", $urandom_range(0, 4), DW'($urandom), -1, 0, g);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
